// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Top-level sequencer for the score/level datapath.
//   - Game FSM: IDLE, RUN, PAUSE, ADJ (level adjust), WON, LOST.
//   - Drives the score/level block controls: i_pause, adj, score, score_clr.
//   - Queues obstacle-cleared events and releases them as score pulses that
//     are separated by at least one idle cycle.
//   - Free-running display refresh tick and a blink enable for ADJ/LOST.
//
// Handshake/pulse semantics: every *_pulse style input (btn_start, btn_pause,
// obstacle_pass, collide) is a single-cycle strobe sampled on the rising clock
// edge; there is no ready/back-pressure. Outputs score, score_clr and
// disp_cycle are single-cycle strobes.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   btn_start       start / acknowledge pulse
//   btn_pause       pause toggle pulse
//   sw_adj          level-adjust switch (level)
//   obstacle_pass   one pulse per obstacle cleared
//   collide         player-hit pulse
//   level_done      level finished flag (level)
//   i_pause         high in PAUSE or ADJ
//   adj             high in ADJ
//   score           one-cycle score pulse
//   score_clr       one-cycle clear of the score/level block
//   disp_cycle      one-cycle display refresh tick
//   blank           blink enable, 1 = digits dark
//   lose            high in LOST
//   state           encoded FSM state (debug/observation)
module game_flow_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned PEND_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       sw_adj,
    input  logic       obstacle_pass,
    input  logic       collide,
    input  logic       level_done,
    output logic       i_pause,
    output logic       adj,
    output logic       score,
    output logic       score_clr,
    output logic       disp_cycle,
    output logic       blank,
    output logic       lose,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_ADJ   = 3'd3,
        ST_WON   = 3'd4,
        ST_LOST  = 3'd5
    } state_t;

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0]     REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0]     BLK_LAST  = BW'(BLINK_DIV - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    state_t            state_q;
    state_t            state_d;
    logic [PEND_W-1:0] pend_q;
    logic              gap_q;
    logic              rst_seen_q;
    logic              score_clr_q;
    logic [RW-1:0]     ref_q;
    logic [BW-1:0]     blk_q;
    logic              blank_q;

    logic emit;
    logic inc;
    logic keep_pend;
    logic blink_zone;

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = btn_start ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (collide)         state_d = ST_LOST;
                else if (level_done) state_d = ST_WON;
                else if (btn_pause)  state_d = ST_PAUSE;
                else                 state_d = ST_RUN;
            end
            // sw_adj has priority, so btn_pause is ignored while it is set
            ST_PAUSE: begin
                if (sw_adj)          state_d = ST_ADJ;
                else if (btn_pause)  state_d = ST_RUN;
                else                 state_d = ST_PAUSE;
            end
            ST_ADJ:   state_d = sw_adj ? ST_ADJ : ST_PAUSE;
            ST_WON:   state_d = btn_start ? ST_IDLE : ST_WON;
            ST_LOST:  state_d = btn_start ? ST_IDLE : ST_LOST;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A collide in the same cycle suppresses both the emit and the increment.
    assign emit = (state_q == ST_RUN) && (pend_q != '0) && !gap_q && !collide;
    // At saturation an increment is only taken when an emit frees a slot.
    assign inc  = (state_q == ST_RUN) && obstacle_pass && !collide &&
                  ((pend_q != PEND_MAX) || emit);
    // The queue survives only RUN/PAUSE/ADJ; any other destination empties it.
    assign keep_pend  = (state_d == ST_RUN) || (state_d == ST_PAUSE) ||
                        (state_d == ST_ADJ);
    assign blink_zone = (state_d == ST_ADJ) || (state_d == ST_LOST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            gap_q       <= 1'b0;
            rst_seen_q  <= 1'b1;
            score_clr_q <= 1'b0;
            ref_q       <= '0;
            blk_q       <= '0;
            blank_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_seen_q <= 1'b0;
            // Clear pulse on the first cycle out of reset or back into IDLE
            // from an end-of-game state.
            score_clr_q <= rst_seen_q ||
                           (((state_q == ST_WON) || (state_q == ST_LOST)) && btn_start);

            if (!keep_pend)
                pend_q <= '0;
            else if (inc && !emit)
                pend_q <= pend_q + PEND_W'(1);
            else if (emit && !inc)
                pend_q <= pend_q - PEND_W'(1);
            gap_q <= emit;

            ref_q <= (ref_q == REF_LAST) ? '0 : ref_q + RW'(1);

            if (!blink_zone || (state_d != state_q)) begin
                // Outside ADJ/LOST, or entering one of them: restart dark-free.
                blk_q   <= '0;
                blank_q <= 1'b0;
            end else if (blk_q == BLK_LAST) begin
                blk_q   <= '0;
                blank_q <= ~blank_q;
            end else begin
                blk_q <= blk_q + BW'(1);
            end
        end
    end

    assign state      = state_q;
    assign i_pause    = (state_q == ST_PAUSE) || (state_q == ST_ADJ);
    assign adj        = (state_q == ST_ADJ);
    assign lose       = (state_q == ST_LOST);
    assign score      = emit;
    assign score_clr  = score_clr_q;
    assign disp_cycle = (ref_q == REF_LAST);
    assign blank      = blank_q;

endmodule
